// File: rtl/pc_fetch_unit.sv
// Program counter and instruction-fetch front end: valid/ready request to
// instruction memory, stall/redirect handling, wrong-path squashing.
module pc_fetch_unit #(
    parameter int              ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int              CNT_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ready,
    input  logic [31:0]       imem_rdata,
    output logic              instr_valid,
    output logic [31:0]       instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic [ADDR_W-1:0] pc,
    output logic [CNT_W-1:0]  fetch_count
);

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        HOLD
    } state_t;

    state_t            state;
    logic              pending;
    logic [ADDR_W-1:0] pend_addr;
    logic              accept;
    logic              keep;
    logic [ADDR_W-1:0] target;
    logic              unused_lsbs;

    assign imem_req    = (state == RUN);
    assign imem_addr   = pc;
    assign accept      = imem_req & imem_ready;
    assign keep        = accept & ~redirect_valid;
    assign target      = {redirect_pc[ADDR_W-1:2], 2'b00};
    assign unused_lsbs = ^redirect_pc[1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= BOOT;
            pc          <= RESET_PC;
            pending     <= 1'b0;
            pend_addr   <= '0;
            instr_valid <= 1'b0;
            instr       <= '0;
            instr_pc    <= '0;
            fetch_count <= '0;
        end else begin
            // Every state leaves on the stall input alone; BOOT only lasts one cycle.
            unique case (state)
                BOOT:    state <= stall ? HOLD : RUN;
                RUN:     state <= stall ? HOLD : RUN;
                HOLD:    state <= stall ? HOLD : RUN;
                default: state <= BOOT;
            endcase

            if (redirect_valid) begin
                pc <= target;
            end else if (accept) begin
                pc <= pc + ADDR_W'(4);
            end

            pending <= keep;
            if (accept) begin
                pend_addr <= pc;
            end

            // A response landing in a redirect cycle is on the wrong path.
            if (pending && !redirect_valid) begin
                instr_valid <= 1'b1;
                instr       <= imem_rdata;
                instr_pc    <= pend_addr;
            end else begin
                instr_valid <= 1'b0;
            end

            if (keep && !(&fetch_count)) begin
                fetch_count <= fetch_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: doc/pc_fetch_unit.md
# pc_fetch_unit

Parametrised program-counter and instruction-fetch front end for the RISC-V core. It replaces the fixed 5-bit PC/address generator with a configurable-width PC, a valid/ready request handshake to instruction memory, stall and branch/jump redirect support, squashing of wrong-path responses, and a saturating fetch counter. It sits between the core's control path and the instruction memory, and feeds fetched instructions to decode.

## Interface
Parameters:
- ADDR_W, 32: PC and memory byte-address width (minimum 3).
- RESET_PC, 0: PC value loaded by reset. Must be 4-byte aligned.
- CNT_W, 16: width of the fetch performance counter.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- stall  in  1  when 1, no new fetch request is issued.
- redirect_valid  in  1  branch/jump taken this cycle.
- redirect_pc  in  ADDR_W  redirect target; bits [1:0] are ignored and treated as 0.
- imem_req  out  1  fetch request valid.
- imem_addr  out  ADDR_W  fetch byte address; always 4-aligned.
- imem_ready  in  1  memory accepts the request this cycle.
- imem_rdata  in  32  instruction data, valid exactly 1 cycle after acceptance.
- instr_valid  out  1  instr/instr_pc hold a valid, non-squashed instruction.
- instr  out  32  fetched instruction.
- instr_pc  out  ADDR_W  address the instruction was fetched from.
- pc  out  ADDR_W  current PC (next address to request).
- fetch_count  out  CNT_W  number of accepted, non-squashed fetches.

## Operation
- Reset values: pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=0, fetch_count=0, state=BOOT, no outstanding fetch.
- FSM states:
  - BOOT: imem_req=0 for exactly one cycle after reset deasserts, then → RUN (or → HOLD if stall=1).
  - RUN: imem_req=1 and imem_addr=pc. Goes → HOLD when stall=1.
  - HOLD: imem_req=0. Goes → RUN when stall=0.
- Acceptance is imem_req & imem_ready in the same cycle. On acceptance, pc ← pc+4, mod 2^ADDR_W (so 2^ADDR_W−4 wraps to 0). The accepted address and a pending flag are registered.
- While imem_req=1 and imem_ready=0, imem_addr is held stable unless a redirect occurs.
- Redirect (redirect_valid=1) takes priority over increment and over stall:
  - pc ← {redirect_pc[ADDR_W-1:2],2'b00} in every state, including HOLD and BOOT.
  - An unaccepted pending request is abandoned; instruction memory must tolerate this.
  - If a fetch is accepted in the redirect cycle, it is squashed.
  - Any response returning in the redirect cycle is also squashed.
- Response handling: one cycle after a non-squashed acceptance:
  - instr ← imem_rdata, instr_pc ← accepted address, instr_valid ← 1.
  - Otherwise instr_valid ← 0; instr and instr_pc hold their previous values.
- fetch_count increments by 1 on each non-squashed acceptance and saturates at 2^CNT_W−1.
- stall has no effect on an already-accepted fetch; its response is still delivered.

## Timing
- Latency from acceptance at edge t to instr_valid high is one cycle: the instruction is visible after edge t+1.
- Throughput: one instruction per cycle when stall=0 and imem_ready is held at 1.
- A redirect at cycle t means imem_addr equals the target in cycle t+1 (if RUN).
- A stall asserted in cycle t drops imem_req in cycle t+1. Acceptance in cycle t is unaffected.
- Reset asserted mid-operation immediately (asynchronously) restores all reset values and clears the pending flag. An in-flight response is never delivered.

## Test plan
- Boot: hold reset 4 cycles, then release with imem_ready=1 → imem_req=0 for 1 cycle. Then imem_addr = 0x0, 0x4, 0x8; instr_valid rises 1 cycle after each acceptance, with matching instr_pc.
- Backpressure: imem_ready=0 for 3 cycles at addr 0x8 → imem_addr stays 0x8 and pc stays 0x8. After ready=1, the next addr is 0xC and fetch_count increments only once.
- Redirect with squash: redirect_pc=0x103 in the same cycle 0x10 is accepted → no instr_valid for 0x10. Next imem_addr=0x100, and 0x100's instruction is then delivered.
- Stall: stall=1 for 2 cycles → imem_req=0 and pc frozen. A redirect to 0x40 during the stall → first request after stall release is 0x40.
- Wrap: ADDR_W=8, RESET_PC=0xF8, ready=1 → addresses 0xF8, 0xFC, 0x00, 0x04. With CNT_W=2, fetch_count saturates at 3.
- Async reset asserted between an acceptance and its response → instr_valid stays 0, pc=RESET_PC, fetch_count=0 immediately.
